// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline definitions: control word and payload layout,
// the NOP control constant and pack/unpack helpers.
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 16;
  localparam int unsigned PIPE_DATA_W = 192;

  // Control word bit offsets (LSB first).
  localparam int unsigned CTL_JUMP      = 0;
  localparam int unsigned CTL_BRANCH    = 1;
  localparam int unsigned CTL_REGWRITE  = 2;
  localparam int unsigned CTL_RESULTSRC = 3;   // 2 bits
  localparam int unsigned CTL_MEMWRITE  = 5;
  localparam int unsigned CTL_ALUCTRL   = 6;   // 4 bits
  localparam int unsigned CTL_ALUSRCA   = 10;
  localparam int unsigned CTL_ALUSRCB   = 11;
  localparam int unsigned CTL_FUNCT3    = 12;  // 3 bits

  // Payload offsets (LSB first), bits 175..191 are zero padding.
  localparam int unsigned DAT_RD1    = 0;
  localparam int unsigned DAT_RD2    = 32;
  localparam int unsigned DAT_IMMEXT = 64;
  localparam int unsigned DAT_PC     = 96;
  localparam int unsigned DAT_INCPC  = 128;
  localparam int unsigned DAT_RD     = 160;
  localparam int unsigned DAT_RS1    = 165;
  localparam int unsigned DAT_RS2    = 170;

  localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic       pad;
    logic [2:0] funct3;
    logic       alusrcb;
    logic       alusrca;
    logic [3:0] aluctrl;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       regwrite;
    logic       branch;
    logic       jump;
  } ctrl_t;

  typedef struct packed {
    logic [16:0] pad;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] inc_pc;
    logic [31:0] pc;
    logic [31:0] immext;
    logic [31:0] rd2;
    logic [31:0] rd1;
  } data_t;

  function automatic logic [PIPE_CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    ctrl_t t;
    t = c;
    t.pad = 1'b0;
    return t;
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [PIPE_CTRL_W-1:0] w);
    return ctrl_t'(w);
  endfunction

  function automatic logic [PIPE_DATA_W-1:0] pack_data(input data_t d);
    data_t t;
    t = d;
    t.pad = '0;
    return t;
  endfunction

  function automatic data_t unpack_data(input logic [PIPE_DATA_W-1:0] w);
    return data_t'(w);
  endfunction

endpackage

// File: rtl/de_pipe_buffer_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/de_pipe_buffer.sv
// Elastic decode-to-execute buffer: DEPTH-entry FIFO with valid/ready on both
// sides, synchronous flush to bubbles, and stall/bubble statistics counters.
module de_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CTRL_W-1:0] mem_ctrl [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              push;
  logic              pop;

  // Both flags come from registered occupancy only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  assign out_ctrl  = out_valid ? mem_ctrl[rd_ptr] : CTRL_W'(CTRL_NOP);
  assign out_data  = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_ctrl[i] <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; an empty count masks it at the output.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_ctrl[wr_ptr] <= in_ctrl;
        mem_data[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_valid & ~in_ready),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_ready & ~out_valid),
    .clr   (cnt_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: doc/de_pipe_buffer.md
Name: de_pipe_buffer

Overview:
- Elastic decode-to-execute pipeline buffer that replaces the fixed stall/flush D/E flop.
- Holds up to DEPTH decoded instructions (control word plus data payload) behind a valid/ready handshake, so decode keeps issuing while execute back-pressures.
- Synchronous flush turns all held entries into bubbles.
- Saturating counters give stall and bubble statistics.

Parameters:
- CTRL_W, 16, control bits (Jump, Branch, RegWrite, ResultSrc, MemWrite, ALUCtrl, ALUSrcA/B, funct3); forced to zero on bubble.
- DATA_W, 192, data payload (RD1, RD2, ImmExt, PC, inc_PC, Rd/Rs1/Rs2, zero-padded).
- DEPTH, 2, number of buffer entries; power of two, >= 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  buffer can accept an instruction this cycle.
- in_ctrl  in  CTRL_W  decoded control word.
- in_data  in  DATA_W  decoded data payload.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  head entry valid toward execute.
- out_ready  in  1  execute consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control word; all zero when out_valid=0.
- out_data  out  DATA_W  head data payload.
- count  out  $clog2(DEPTH)+1  current occupancy.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0.

Behaviour:
- Reset (rst_n=0, async):
  - Pointers, count, stall_cnt and bubble_cnt go to 0.
  - Storage array clears to 0.
  - Hence out_valid=0, out_ctrl=0, out_data=0 and in_ready=1.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Transfers happen on the rising clk edge.
- Readiness and validity:
  - in_ready = (count < DEPTH), taken from registered state only. There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). There is no same-cycle bypass.
- Order and storage:
  - Strict FIFO order.
  - Write pointer and read pointer wrap modulo DEPTH.
  - count goes +1 on push only, -1 on pop only, and is unchanged on push & pop.
- Head outputs:
  - out_ctrl/out_data are the storage entry at the read pointer.
  - out_ctrl is masked to 0 whenever out_valid=0, which gives NOP semantics downstream.
- Full: in_ready=0 and no push. A pop in the same cycle raises in_ready only in the following cycle.
- Empty:
  - out_valid=0 and out_ctrl=0.
  - A pop is impossible; out_ready is ignored except for bubble_cnt.
- Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head on the next cycle.
- Flush (priority over everything):
  - At the edge: count:=0 and both pointers:=0.
  - The push in the same cycle is discarded and the pop in the same cycle has no effect.
  - Storage contents are left untouched; they are masked by out_valid.
  - in_ready is 1 in the next cycle.
- Counters:
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr zeroes both and takes priority over increment.
  - Counters are not affected by flush.
- Reset mid-operation: all state returns to reset values immediately and in-flight entries are lost. Outputs are valid one edge after rst_n deasserts.

Decomposition:
- Shared package pipe_pkg:
  - Field offsets and widths of the control word and payload (CTRL_W=16, DATA_W=192 layout).
  - NOP control constant (all zero).
  - Helper function to pack and unpack fields.
- Sub-module sat_counter (CNT_W, inc, clr, clk, rst_n): instantiated twice for stall_cnt and bubble_cnt.
- The FIFO core stays inline.

Test Plan:
- Reset, then idle with out_ready=1 for 5 cycles:
  - in_ready=1, out_valid=0, out_ctrl=0 and count=0 throughout.
  - bubble_cnt=5.
- Fill to full and drain:
  - Setup: out_ready=0; push ctrl 0x0001 then 0x0002 on consecutive cycles.
  - Full state: count=2, in_ready=0, out_ctrl=0x0001.
  - Hold in_valid=1 for 3 more cycles: stall_cnt=3.
  - Raise out_ready: pops in order 0x0001 then 0x0002, then out_valid=0.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously with ctrl values 1..10.
  - Response: out_ctrl yields 1..10 in order, each one cycle after its push; count stays 1; stall_cnt=0.
- Flush with a full buffer plus a concurrent push of 0x00FF:
  - Next cycle count=0, out_valid=0, out_ctrl=0 and in_ready=1.
  - 0x00FF never appears at the output.
- Async reset asserted mid-stream with count=2:
  - Outputs drop to reset values before the next clk edge.
  - After release, the first push of 0x0003 is the first value seen at the output.
- Counter saturation (CNT_W=4 build): after 20 stall cycles stall_cnt=15; cnt_clr then gives 0.
